// File: rtl/nand_flash_target.sv
`default_nettype none
// ============================================================================
// Module      : nand_flash_target
// Description : Device-side NAND flash pin responder. Decodes CLE/ALE/WEN
//               cycles, times R/B busy periods and streams page data to and
//               from a 512x512-byte backing SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module nand_flash_target #(
    parameter int T_R    = 8,
    parameter int T_PROG = 16,
    parameter int T_RST  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cle,
    input  logic        ale,
    input  logic        ren,
    input  logic        wen,
    input  logic [7:0]  io_in,
    output logic [7:0]  io_out,
    output logic        io_oe,
    output logic        rb,
    output logic [17:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic        cmd_err
);

    localparam int c_T_MAX = (T_PROG > T_R) ? ((T_PROG > T_RST) ? T_PROG : T_RST)
                                            : ((T_R > T_RST) ? T_R : T_RST);
    localparam int c_CNT_W = $clog2(c_T_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_LEN_R    = c_CNT_W'(T_R - 1);
    localparam logic [c_CNT_W-1:0] c_LEN_PROG = c_CNT_W'(T_PROG - 1);
    localparam logic [c_CNT_W-1:0] c_LEN_RST  = c_CNT_W'(T_RST - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_BUSY_R   = 3'd2,
        S_RD_DATA  = 3'd3,
        S_WR_DATA  = 3'd4,
        S_BUSY_P   = 3'd5,
        S_STATUS   = 3'd6,
        S_BUSY_RST = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        K_READ = 2'd0,
        K_PROG = 2'd1,
        K_RST  = 2'd2
    } kind_t;

    state_t               r_state, w_state_nxt;
    kind_t                r_kind, w_kind_nxt, w_start_kind;
    logic                 r_wen_q, r_ren_q;
    logic [8:0]           r_col, r_page;
    logic [1:0]           r_addr_cnt;
    logic                 r_prog, r_busy, r_rd_done, r_pend;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt, w_start_len;
    logic [7:0]           r_rdata, r_mem_wdata;
    logic [17:0]          r_mem_addr;
    logic                 r_mem_we, r_mem_re, r_cmd_err;

    logic w_latch, w_cmd, w_adr, w_dat, w_ren_rise;
    logic w_start, w_busy_nxt, w_done, w_prefetch;
    logic w_new_seq, w_seq_prog, w_col_hi, w_wr, w_step, w_cmd_err;
    logic [8:0] w_col_inc;
    logic [7:0] w_byte;

    assign w_latch    = ~r_wen_q & wen;
    assign w_cmd      = w_latch & cle & ~ale;
    assign w_adr      = w_latch & ale & ~cle;
    assign w_dat      = w_latch & ~cle & ~ale;
    assign w_ren_rise = ~r_ren_q & ren;
    assign w_col_inc  = r_col + 9'd1;

    // Next-state and command decode
    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_start_kind = K_READ;
        w_start_len  = '0;
        w_new_seq    = 1'b0;
        w_seq_prog   = 1'b0;
        w_col_hi     = 1'b0;
        w_wr         = 1'b0;
        w_step       = 1'b0;
        w_cmd_err    = 1'b0;

        if (r_busy && (r_cnt == '0)) begin
            if (r_state == S_BUSY_R) begin
                w_state_nxt = S_RD_DATA;
            end else if ((r_state == S_BUSY_P) || (r_state == S_BUSY_RST)) begin
                w_state_nxt = S_IDLE;
            end
        end

        if (w_cmd) begin
            if (io_in == 8'hFF) begin
                w_start      = 1'b1;
                w_start_kind = K_RST;
                w_start_len  = c_LEN_RST;
                w_state_nxt  = S_BUSY_RST;
            end else if (io_in == 8'h70) begin
                w_state_nxt = S_STATUS;
            end else if (!r_busy) begin
                case (io_in)
                    8'h00, 8'h01: begin
                        if ((io_in == 8'h00) && (r_state == S_STATUS) && r_rd_done) begin
                            w_state_nxt = S_RD_DATA;
                        end else begin
                            w_new_seq   = 1'b1;
                            w_col_hi    = io_in[0];
                            w_state_nxt = S_ADDR;
                        end
                    end
                    8'h80: begin
                        w_new_seq   = 1'b1;
                        w_seq_prog  = 1'b1;
                        w_state_nxt = S_ADDR;
                    end
                    8'h10: begin
                        if (r_state == S_WR_DATA) begin
                            w_start      = 1'b1;
                            w_start_kind = K_PROG;
                            w_start_len  = c_LEN_PROG;
                            w_state_nxt  = S_BUSY_P;
                        end else begin
                            w_cmd_err = 1'b1;
                        end
                    end
                    default: w_cmd_err = 1'b1;
                endcase
            end
        end else if (w_adr && (r_state == S_ADDR) && (r_addr_cnt == 2'd2)) begin
            if (r_prog) begin
                w_state_nxt = S_WR_DATA;
            end else begin
                w_start      = 1'b1;
                w_start_kind = K_READ;
                w_start_len  = c_LEN_R;
                w_state_nxt  = S_BUSY_R;
            end
        end else if (w_dat && (r_state == S_WR_DATA)) begin
            w_wr = 1'b1;
        end else if (w_ren_rise && (r_state == S_RD_DATA)) begin
            w_step = 1'b1;
        end
    end

    // The busy countdown is independent of the state so status polls do not stall it
    always_comb begin
        w_busy_nxt = r_busy;
        w_cnt_nxt  = r_cnt;
        w_kind_nxt = r_kind;
        if (w_start) begin
            w_busy_nxt = 1'b1;
            w_cnt_nxt  = w_start_len;
            w_kind_nxt = w_start_kind;
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                w_busy_nxt = 1'b0;
            end else begin
                w_cnt_nxt = r_cnt - 1'b1;
            end
        end
    end

    assign w_done     = r_busy && (r_cnt == '0) && !w_start;
    assign w_prefetch = w_busy_nxt && (w_kind_nxt == K_READ) && (w_cnt_nxt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wen_q     <= 1'b1;
            r_ren_q     <= 1'b1;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_kind      <= K_READ;
            r_col       <= '0;
            r_page      <= '0;
            r_addr_cnt  <= '0;
            r_prog      <= 1'b0;
            r_rd_done   <= 1'b0;
            r_pend      <= 1'b0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_wen_q   <= wen;
            r_ren_q   <= ren;
            r_busy    <= w_busy_nxt;
            r_cnt     <= w_cnt_nxt;
            r_kind    <= w_kind_nxt;
            r_mem_we  <= 1'b0;
            r_mem_re  <= 1'b0;
            r_cmd_err <= w_cmd_err;
            r_pend    <= r_mem_re;
            if (r_pend) begin
                r_rdata <= mem_rdata;
            end

            if (w_done && (r_kind == K_READ)) begin
                r_rd_done <= 1'b1;
            end

            if (w_start && (w_start_kind == K_RST)) begin
                r_rd_done  <= 1'b0;
                r_addr_cnt <= '0;
            end else if (w_new_seq) begin
                r_col[8]   <= w_col_hi;
                r_addr_cnt <= '0;
                r_prog     <= w_seq_prog;
                r_rd_done  <= 1'b0;
            end else if (w_adr && (r_state == S_ADDR)) begin
                case (r_addr_cnt)
                    2'd0:    r_col[7:0]  <= io_in;
                    2'd1:    r_page[7:0] <= io_in;
                    default: r_page[8]   <= io_in[0];
                endcase
                r_addr_cnt <= (r_addr_cnt == 2'd2) ? 2'd0 : r_addr_cnt + 2'd1;
            end else if (w_wr) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= {r_page, r_col};
                r_mem_wdata <= io_in;
                r_col       <= w_col_inc;
            end else if (w_step) begin
                r_mem_re   <= 1'b1;
                r_mem_addr <= {r_page, w_col_inc};
                r_col      <= w_col_inc;
            end

            // Prefetch lands in the last busy cycle of a read
            if (w_prefetch) begin
                r_mem_re   <= 1'b1;
                r_mem_addr <= {r_page, r_col};
            end
        end
    end

    // Bypass lets a byte fetched on REN rise be driven before it is registered
    assign w_byte = r_pend ? mem_rdata : r_rdata;

    assign rb        = ~r_busy;
    assign io_oe     = ~ren & ~w_latch & ((r_state == S_RD_DATA) || (r_state == S_STATUS));
    assign io_out    = !io_oe ? 8'h00 :
                       (r_state == S_STATUS) ? {1'b1, rb, 6'b0} : w_byte;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign mem_re    = r_mem_re;
    assign cmd_err   = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_nand_flash_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_nand_flash_target
// Description : Directed/randomized bench for nand_flash_target with an
//               SRAM model and a flat expected-memory reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nand_flash_target;

    localparam int T_R    = 8;
    localparam int T_PROG = 16;
    localparam int T_RST  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cle = 1'b0;
    logic        ale = 1'b0;
    logic        ren = 1'b1;
    logic        wen = 1'b1;
    logic [7:0]  io_in = 8'h00;
    logic [7:0]  io_out;
    logic        io_oe;
    logic        rb;
    logic [17:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        cmd_err;

    logic [7:0]  sram  [0:262143];
    logic [7:0]  model [0:262143];

    int          n_vec = 0;
    int          n_err = 0;
    int          busy_run = 0;
    int          busy_len = 0;
    int          we_cnt = 0;
    int          err_cyc = 0;
    logic [17:0] we_first = '0;
    logic [17:0] we_last = '0;

    always #5 clk = ~clk;

    nand_flash_target #(.T_R(T_R), .T_PROG(T_PROG), .T_RST(T_RST)) dut (
        .clk(clk), .rst(rst), .cle(cle), .ale(ale), .ren(ren), .wen(wen),
        .io_in(io_in), .io_out(io_out), .io_oe(io_oe), .rb(rb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .cmd_err(cmd_err)
    );

    always @(posedge clk) begin
        if (mem_we) sram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= sram[mem_addr];
    end

    always @(negedge clk) begin
        if (!rst) busy_run = 0;
        else if (!rb) busy_run++;
        else if (busy_run != 0) begin
            busy_len = busy_run;
            busy_run = 0;
        end
        if (mem_we) begin
            if (we_cnt == 0) we_first = mem_addr;
            we_last = mem_addr;
            we_cnt++;
        end
        if (cmd_err) err_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic latch(input logic c, input logic a, input logic [7:0] v);
        @(negedge clk);
        cle = c; ale = a; io_in = v; wen = 1'b0;
        repeat (2) @(negedge clk);
        wen = 1'b1;
        repeat (2) @(negedge clk);
        cle = 1'b0; ale = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] v);  latch(1'b1, 1'b0, v); endtask
    task automatic dat(input logic [7:0] v);  latch(1'b0, 1'b0, v); endtask

    task automatic addr3(input logic [7:0] c, input logic [8:0] p);
        latch(1'b0, 1'b1, c);
        latch(1'b0, 1'b1, p[7:0]);
        latch(1'b0, 1'b1, {7'b0, p[8]});
    endtask

    task automatic readb(output logic [7:0] v, output logic oe);
        @(negedge clk);
        ren = 1'b0;
        repeat (2) @(negedge clk);
        v  = io_out;
        oe = io_oe;
        ren = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_ready(input string tag, input int exp_len);
        for (int i = 0; i < 200 && rb !== 1'b1; i++) @(negedge clk);
        chk({tag, "_timeout"}, {31'b0, rb}, 32'd1);
        @(negedge clk);
        chk({tag, "_len"}, busy_len, exp_len);
    endtask

    task automatic chk_page(input string tag, input logic [8:0] p);
        for (int c = 0; c < 512; c++)
            chk(tag, sram[{p, 9'(c)}], model[{p, 9'(c)}]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b;
        logic        oe;
        logic [8:0]  rp, qp;
        logic [8:0]  rc;
        int          we0, e0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rb", {31'b0, rb}, 32'd1);
        chk("rst_io_oe", {31'b0, io_oe}, 32'd0);
        chk("rst_io_out", {24'b0, io_out}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_re", {31'b0, mem_re}, 32'd0);
        chk("rst_mem_addr", {14'b0, mem_addr}, 32'd0);
        chk("rst_cmd_err", {31'b0, cmd_err}, 32'd0);
        rst = 1'b1;

        cmd(8'hFF);
        wait_ready("reset_cmd", T_RST);

        // Program page 5 with 00..FF repeating
        we0 = we_cnt;
        cmd(8'h80);
        addr3(8'h00, 9'd5);
        for (int i = 0; i < 512; i++) begin
            dat(8'(i));
            model[{9'd5, 9'(i)}] = 8'(i);
        end
        cmd(8'h10);
        wait_ready("prog_pg5", T_PROG);
        chk("prog_we_count", we_cnt - we0, 32'd512);
        chk("prog_we_first", {14'b0, we_first}, 32'h0A00);
        chk("prog_we_last", {14'b0, we_last}, 32'h0BFF);
        chk_page("pg5_contents", 9'd5);

        // Read back with column wrap
        cmd(8'h00);
        addr3(8'h00, 9'd5);
        wait_ready("read_pg5", T_R);
        for (int i = 0; i < 513; i++) begin
            readb(b, oe);
            if (i == 0) chk("read_oe", {31'b0, oe}, 32'd1);
            chk("read_pg5", {24'b0, b}, {24'b0, model[{9'd5, 9'(i % 512)}]});
        end

        // Illegal commands pulse cmd_err and leave the read stream in place
        e0 = err_cyc;
        cmd(8'h3C);
        chk("err_3c", err_cyc - e0, 32'd1);
        readb(b, oe);
        chk("after_3c", {24'b0, b}, {24'b0, model[{9'd5, 9'd1}]});
        e0 = err_cyc;
        cmd(8'h10);
        chk("err_10", err_cyc - e0, 32'd1);
        readb(b, oe);
        chk("after_10", {24'b0, b}, {24'b0, model[{9'd5, 9'd2}]});

        // Second half-page area
        cmd(8'h01);
        addr3(8'h10, 9'd5);
        wait_ready("read_b", T_R);
        readb(b, oe);
        chk("area_b", {24'b0, b}, {24'b0, model[{9'd5, 9'h110}]});
        chk_page("pg5_unchanged", 9'd5);

        // Random page program, status polled while busy
        rp = 9'($urandom_range(0, 511));
        if (rp == 9'd5) rp = 9'd6;
        rc = 9'($urandom_range(0, 255));
        cmd(8'h80);
        addr3(rc[7:0], rp);
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            dat(b);
            model[{rp, 9'(rc + 9'(i))}] = b;
        end
        cmd(8'h10);
        cmd(8'h70);
        readb(b, oe);
        chk("status_busy", {24'b0, b}, 32'h80);
        chk("status_oe", {31'b0, oe}, 32'd1);
        wait_ready("prog_rand", T_PROG);
        readb(b, oe);
        chk("status_ready", {24'b0, b}, 32'hC0);

        cmd(8'h00);
        addr3(rc[7:0], rp);
        wait_ready("read_rand", T_R);
        for (int i = 0; i < 7; i++) begin
            readb(b, oe);
            chk("read_rand", {24'b0, b}, {24'b0, model[{rp, 9'(rc + 9'(i))}]});
        end
        cmd(8'h70);
        readb(b, oe);
        chk("status_after_read", {24'b0, b}, 32'hC0);
        cmd(8'h00);
        readb(b, oe);
        chk("resume_read", {24'b0, b}, {24'b0, model[{rp, 9'(rc + 9'd7)}]});

        // Abort a program after 10 bytes
        qp = 9'($urandom_range(256, 511));
        we0 = we_cnt;
        cmd(8'h80);
        addr3(8'h00, qp);
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            dat(b);
            model[{qp, 9'(i)}] = b;
        end
        cmd(8'hFF);
        wait_ready("abort", T_RST);
        chk("abort_we_count", we_cnt - we0, 32'd10);
        for (int i = 0; i < 10; i++)
            chk("abort_data", {24'b0, sram[{qp, 9'(i)}]}, {24'b0, model[{qp, 9'(i)}]});
        readb(b, oe);
        chk("abort_idle_oe", {31'b0, oe}, 32'd0);

        // Asynchronous reset during read busy
        cmd(8'h00);
        addr3(8'h00, 9'd5);
        @(negedge clk);
        chk("busy_before_rst", {31'b0, rb}, 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_rb", {31'b0, rb}, 32'd1);
        chk("async_rst_oe", {31'b0, io_oe}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cmd(8'h00);
        addr3(8'h20, 9'd5);
        wait_ready("read_after_rst", T_R);
        for (int i = 0; i < 4; i++) begin
            readb(b, oe);
            chk("read_after_rst", {24'b0, b}, {24'b0, model[{9'd5, 9'(32 + i)}]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nand_flash_target.md
Name: nand_flash_target

Overview:
- Synthesizable NAND flash device-side interface: the responder at the far end of the NFC flash pin bus (CLE/ALE/REN/WEN/IO/RB).
- Decodes command, address and data cycles from a controller and drives R/B busy for fixed array times.
- Returns read data and status on IO; writes program data into a 512-byte-page, 512-page backing SRAM through a simple memory port.
- Lets the NFC be exercised against RTL flash instead of the behavioural flash_a/flash_b models.

Parameters:
- T_R, 8: busy cycles after a read-address sequence completes.
- T_PROG, 16: busy cycles after program confirm (10h).
- T_RST, 4: busy cycles after reset command (FFh).

Ports:
- clk  in  1  system clock; all pin inputs are synchronous to it.
- rst  in  1  asynchronous, active-low reset.
- cle  in  1  command latch enable.
- ale  in  1  address latch enable.
- ren  in  1  read enable, active low.
- wen  in  1  write enable, active low.
- io_in  in  8  IO bus value driven by the controller.
- io_out  out  8  IO bus value driven by this block.
- io_oe  out  1  IO output enable.
- rb  out  1  ready/busy: 1 = ready.
- mem_addr  out  18  SRAM address {page[8:0], col[8:0]}.
- mem_wdata  out  8  SRAM write data.
- mem_we  out  1  SRAM write strobe, one cycle per byte.
- mem_re  out  1  SRAM read strobe.
- mem_rdata  in  8  SRAM read data, valid 1 cycle after mem_re.
- cmd_err  out  1  one-cycle pulse on an unsupported or illegal command.

Behaviour:
- Reset values (rst=0, asynchronous): io_out=0, io_oe=0, rb=1, mem_we=0, mem_re=0, cmd_err=0, mem_addr=0, mem_wdata=0, state IDLE, col=0, page=0, addr_cnt=0.
- Latching:
  - wen and ren are registered once (wen_q, ren_q).
  - Latch event = wen rising edge (wen_q=0, wen=1); io_in is captured in that cycle.
  - cle=1 marks a command cycle; ale=1 marks an address cycle; both 0 marks a data cycle; both 1 is ignored.
  - The controller holds wen/ren low at least 2 clk and high at least 2 clk.
- States: IDLE, ADDR, BUSY_R, RD_DATA, WR_DATA, BUSY_P, STATUS, BUSY_RST.
- Commands:
  - 00h: col[8]=0, go to ADDR (read).
  - 01h: col[8]=1, go to ADDR (read).
  - 80h: go to ADDR (program).
  - 10h: valid only in WR_DATA; go to BUSY_P.
  - 70h: go to STATUS from any state; the busy countdown keeps running.
  - FFh: from any state, abort and go to BUSY_RST; no partial program rollback is performed.
  - Any other command, or 10h outside WR_DATA: cmd_err pulse, state unchanged.
  - While rb=0, only 70h and FFh are accepted; other commands are ignored silently.
- Address cycles:
  - Cycle 1: col[7:0].
  - Cycle 2: page[7:0].
  - Cycle 3: page[8] = io_in[0]; bits [7:1] are ignored.
  - Address cycles outside ADDR are ignored.
  - A read sequence's 3rd address cycle goes to BUSY_R; a program sequence's goes to WR_DATA.
- Busy timing:
  - rb falls the clock after the triggering latch event and stays 0 exactly T_R, T_PROG or T_RST cycles.
  - BUSY_R then goes to RD_DATA.
  - BUSY_P and BUSY_RST then go to IDLE.
  - In the last BUSY_R cycle, mem_re is issued for {page,col} to prefetch.
- RD_DATA:
  - While ren=0: io_oe=1 and io_out = prefetched byte.
  - On ren rising edge: col increments, mem_re is issued for the next byte, and the next byte is captured the following cycle.
  - col wraps 511 -> 0 within the same page.
  - Extra REN pulses keep streaming with wrap.
- WR_DATA: each data-cycle latch event gives mem_we=1 for one cycle with mem_addr={page,col} and mem_wdata=io_in, then col increments with the same 511 -> 0 wrap.
- STATUS:
  - While ren=0: io_oe=1 and io_out={1'b1, rb, 6'b0}, i.e. C0h when ready and 80h when busy.
  - After status, a 00h command returns to RD_DATA only if the read had completed; otherwise the normal 00h flow applies.
- io_oe is 1 only while ren=0 in RD_DATA or STATUS; otherwise io_out=0. io_oe never rises during a latch event.
- Reset mid-operation (rst=0) returns everything to reset values immediately; a partial page program is left as written.

Test Plan:
- Program: FFh, then 80h, addr 00/05/00, 512 data bytes 00..FF repeating, then 10h -> rb low exactly 16 cycles; SRAM page 5 holds the pattern; 512 mem_we pulses with addresses 0A00h..0BFFh.
- Read back: 00h, addr 00/05/00 -> rb low 8 cycles; 512 REN pulses return 00..FF twice; a 513th pulse returns 00h (col wrap).
- Area B: 01h, addr 10/05/00 -> first byte returned is from column 110h (value 10h); page 5 unchanged.
- Status during program: issue 70h while BUSY_P -> io reads 80h; after busy ends, a further REN pulse reads C0h.
- Errors/abort: command 3Ch -> cmd_err for 1 cycle, state unchanged; FFh during WR_DATA after 10 bytes -> rb low 4 cycles, then IDLE, with the 10 bytes written.
- Async reset asserted during BUSY_R -> rb=1, io_oe=0 within the same cycle; a subsequent full read sequence works normally.
